// File: rtl/lut_ser_pkg.sv
// Shared types and elaboration helpers for the LUT table serializer.
package lut_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Keeps zero-width counters and selects out of the netlist.
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 32'd1 : v;
    endfunction

    function automatic int unsigned table_bits(input int unsigned in_w, input int unsigned out_w);
        return (32'd1 << in_w) * out_w;
    endfunction

    function automatic int unsigned pad_bits(input int unsigned shift_len, input int unsigned in_w,
                                             input int unsigned out_w);
        return shift_len - table_bits(in_w, out_w);
    endfunction

endpackage

// File: rtl/lut_table_serializer_if.sv
// Host-side bus of the serializer: table write port, load handshake and loader pins.
interface lut_table_serializer_if #(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 4
);
    logic                 wr_en;
    logic [IN_WIDTH-1:0]  wr_addr;
    logic [OUT_WIDTH-1:0] wr_data;
    logic                 wr_drop;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 sd;
    logic                 sclk;
    logic                 scs_n;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  wr_drop, busy, done, sd, sclk, scs_n
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output wr_drop, busy, done, sd, sclk, scs_n
    );
endinterface

// File: rtl/lut_table_regfile.sv
// Truth-table storage: one write port, one combinational read port.
module lut_table_regfile #(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IN_WIDTH-1:0]  wa,
    input  logic [OUT_WIDTH-1:0] wd,
    input  logic [IN_WIDTH-1:0]  ra,
    output logic [OUT_WIDTH-1:0] rd_data_c
);
    localparam int unsigned ENTRIES = 32'd1 << IN_WIDTH;

    logic [OUT_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd_data_c = mem[ra];
endmodule

// File: rtl/lut_table_serializer.sv
// Streams the local truth table to the serial-load LUT as pad bits followed by
// entries high index first, MSB first, on a divided sclk framed by scs_n.
module lut_table_serializer
    import lut_ser_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 4,
    parameter int unsigned SHIFT_LEN = 2 ** (IN_WIDTH + OUT_WIDTH),
    parameter int unsigned DIV       = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    lut_table_serializer_if.slave bus
);
    localparam int unsigned N       = SHIFT_LEN;
    localparam int unsigned ENTRIES = 32'd1 << IN_WIDTH;
    localparam int unsigned PAD     = pad_bits(SHIFT_LEN, IN_WIDTH, OUT_WIDTH);
    localparam int unsigned BW      = clog2(N + 1);
    localparam int unsigned PW      = at_least_one(clog2(DIV));
    localparam int unsigned SW      = at_least_one(clog2(OUT_WIDTH));

    state_t               state, state_d;
    logic [PW-1:0]        phase_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 phase_last, hold;
    logic [BW-1:0]        idx, j, ent;
    logic                 in_tab, stream_bit;
    logic [IN_WIDTH-1:0]  rd_addr;
    logic [SW-1:0]        bsel;
    logic [OUT_WIDTH-1:0] rd_data_c;
    logic sd_q, sclk_q, scs_n_q, busy_q, done_q, drop_q;
    logic sd_d, sclk_d, scs_n_d, busy_d, done_d, drop_d;

    assign phase_last = (phase_cnt == PW'(DIV - 1));
    assign hold       = (bit_cnt == BW'(N));

    lut_table_regfile #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bus.wr_en && (state == IDLE)),
        .wa       (bus.wr_addr),
        .wd       (bus.wr_data),
        .ra       (rd_addr),
        .rd_data_c(rd_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (phase_last) state_d = HIGH;
            HIGH:    if (phase_last) state_d = LOW;
            LOW:     if (phase_last) state_d = hold ? IDLE : HIGH;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter restarts on every state change; bit counter counts completed HIGH phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
        end else begin
            if (state == IDLE || state_d != state) phase_cnt <= '0;
            else                                   phase_cnt <= phase_cnt + PW'(1);
            if (state == IDLE && state_d == SETUP)     bit_cnt <= '0;
            else if (state == HIGH && state_d == LOW)  bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Stream bit about to be presented: bit 0 when leaving IDLE, else the one after the current.
    always_comb begin
        idx        = (state == IDLE) ? '0 : bit_cnt + BW'(1);
        in_tab     = (idx >= BW'(PAD)) && (idx < BW'(N));
        j          = idx - BW'(PAD);
        ent        = j / BW'(OUT_WIDTH);
        rd_addr    = IN_WIDTH'(BW'(ENTRIES - 1) - ent);
        bsel       = SW'(BW'(OUT_WIDTH - 1) - (j % BW'(OUT_WIDTH)));
        stream_bit = in_tab && rd_data_c[bsel];
    end

    always_comb begin
        sd_d    = sd_q;
        sclk_d  = (state_d == HIGH);
        scs_n_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state == LOW) && (state_d == IDLE);
        drop_d  = bus.wr_en && (state != IDLE);
        if (state_d == IDLE)                      sd_d = 1'b0;
        else if (state == IDLE)                   sd_d = stream_bit;
        else if (state == HIGH && state_d == LOW) sd_d = stream_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_q    <= 1'b0;
            sclk_q  <= 1'b0;
            scs_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            sd_q    <= sd_d;
            sclk_q  <= sclk_d;
            scs_n_q <= scs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.sd      = sd_q;
    assign bus.sclk    = sclk_q;
    assign bus.scs_n   = scs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_drop = drop_q;
endmodule

// File: tb/tb_lut_table_serializer.sv
// Bench for lut_table_serializer: two instances (DIV=1, DIV=3) checked every cycle
// against a timing/loader model, plus hand-computed literal expectations.
module tb_lut_table_serializer;
    localparam int N = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_table_serializer_if #(.IN_WIDTH(4), .OUT_WIDTH(4)) if0 ();
    lut_table_serializer_if #(.IN_WIDTH(4), .OUT_WIDTH(4)) if1 ();

    lut_table_serializer #(.IN_WIDTH(4), .OUT_WIDTH(4), .SHIFT_LEN(256), .DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    lut_table_serializer #(.IN_WIDTH(4), .OUT_WIDTH(4), .SHIFT_LEN(256), .DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    logic       wr_en_v [2];
    logic [3:0] wr_addr_v [2];
    logic [3:0] wr_data_v [2];
    logic       start_v [2];
    logic sd_w [2], sclk_w [2], scs_w [2], busy_w [2], done_w [2], drop_w [2];

    assign if0.wr_en = wr_en_v[0];  assign if0.wr_addr = wr_addr_v[0];
    assign if0.wr_data = wr_data_v[0];  assign if0.start = start_v[0];
    assign if1.wr_en = wr_en_v[1];  assign if1.wr_addr = wr_addr_v[1];
    assign if1.wr_data = wr_data_v[1];  assign if1.start = start_v[1];
    assign sd_w[0] = if0.sd;  assign sclk_w[0] = if0.sclk;  assign scs_w[0] = if0.scs_n;
    assign busy_w[0] = if0.busy;  assign done_w[0] = if0.done;  assign drop_w[0] = if0.wr_drop;
    assign sd_w[1] = if1.sd;  assign sclk_w[1] = if1.sclk;  assign scs_w[1] = if1.scs_n;
    assign busy_w[1] = if1.busy;  assign done_w[1] = if1.done;  assign drop_w[1] = if1.wr_drop;

    int checks   = 0;
    int failures = 0;

    // Model: table as a 64-bit vector (entry k at bits 4k+3..4k), so the loader image is {pad, table}.
    logic [63:0] mtab [2], ftab [2];
    logic        mbusy [2], mdone [2], mdrop [2];
    int          mt [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int len_of(input int i);
        return div_of(i) * (1 + 2 * N);
    endfunction

    function automatic logic [63:0] with_write(input logic [63:0] v, input logic en,
                                               input logic [3:0] a, input logic [3:0] d);
        if (en) v[int'(a) * 4 +: 4] = d;
        return v;
    endfunction

    // Expected {sd, sclk, scs_n, busy} at busy cycle t; stream bit i lands at loader position N-1-i.
    function automatic logic [3:0] exp_out(input int div, input int t, input logic [255:0] im);
        int p, h;
        logic s;
        if (t < div) return {im[N-1], 1'b0, 1'b0, 1'b1};
        p = (t - div) / div;
        h = p / 2;
        if (p % 2 == 0) return {im[N-1-h], 1'b1, 1'b0, 1'b1};
        s = (h + 1 < N) ? im[N-2-h] : 1'b0;
        return {s, 1'b0, 1'b0, 1'b1};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mtab[i] <= '0;  ftab[i] <= '0;  mbusy[i] <= 1'b0;
                mdone[i] <= 1'b0;  mdrop[i] <= 1'b0;  mt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mdrop[i] <= mbusy[i] && wr_en_v[i];
                mdone[i] <= 1'b0;
                if (mbusy[i]) begin
                    mt[i] <= mt[i] + 1;
                    if (mt[i] + 1 == len_of(i)) begin
                        mbusy[i] <= 1'b0;
                        mdone[i] <= 1'b1;
                    end
                end else begin
                    mtab[i] <= with_write(mtab[i], wr_en_v[i], wr_addr_v[i], wr_data_v[i]);
                    if (start_v[i]) begin
                        ftab[i]  <= with_write(mtab[i], wr_en_v[i], wr_addr_v[i], wr_data_v[i]);
                        mbusy[i] <= 1'b1;
                        mt[i]    <= 0;
                    end
                end
            end
        end
    end

    // Loader model and trackers, fed by the DUT pins.
    logic [255:0] img [2], last_img [2];
    int           rises [2], last_rises [2], bcnt [2], last_len [2], dcount [2];
    int           gapc [2], last_gap [2];
    logic         prev_sclk [2];

    always @(negedge clk) begin : cmp
        logic [3:0] e, a;
        for (int i = 0; i < 2; i++) begin
            e = mbusy[i] ? exp_out(div_of(i), mt[i], {192'b0, ftab[i]}) : 4'b0010;
            a = {sd_w[i], sclk_w[i], scs_w[i], busy_w[i]};
            checks++;
            if (a !== e || done_w[i] !== mdone[i] || drop_w[i] !== mdrop[i]) begin
                failures++;
                $display("FAIL pins inst%0d t=%0t: sd,sclk,scs_n,busy,done,wr_drop got %b%b%b expected %b%b%b",
                         i, $time, a, done_w[i], drop_w[i], e, mdone[i], mdrop[i]);
            end
            if (!rst_n) begin
                img[i] <= '0;  rises[i] <= 0;  prev_sclk[i] <= 1'b0;  bcnt[i] <= 0;  gapc[i] <= 0;
            end else begin
                prev_sclk[i] <= sclk_w[i];
                if (sclk_w[i] && !prev_sclk[i]) begin
                    img[i]   <= {img[i][254:0], sd_w[i]};
                    rises[i] <= rises[i] + 1;
                end
                if (busy_w[i]) bcnt[i] <= bcnt[i] + 1;
                if (done_w[i]) begin
                    last_len[i] <= bcnt[i];
                    bcnt[i]     <= 0;
                    dcount[i]   <= dcount[i] + 1;
                end
                if (scs_w[i]) gapc[i] <= gapc[i] + 1;
                else if (gapc[i] != 0) begin
                    last_gap[i] <= gapc[i];
                    gapc[i]     <= 0;
                end
                if (mdone[i]) begin
                    checks++;
                    if (rises[i] != N || img[i] !== {192'b0, ftab[i]}) begin
                        failures++;
                        $display("FAIL loader inst%0d: rises=%0d image=%h expected rises=%0d image=%h",
                                 i, rises[i], img[i], N, {192'b0, ftab[i]});
                    end
                    last_img[i]   <= img[i];
                    last_rises[i] <= rises[i];
                    rises[i]      <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input int i, input logic [3:0] a, input logic [3:0] d);
        wr_en_v[i] = 1'b1;  wr_addr_v[i] = a;  wr_data_v[i] = d;
        @(negedge clk);
        wr_en_v[i] = 1'b0;
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (busy_w[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle busy", busy_w[i], 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, nd, d0;
        for (int i = 0; i < 2; i++) begin
            wr_en_v[i] = 1'b0;  wr_addr_v[i] = '0;  wr_data_v[i] = '0;  start_v[i] = 1'b0;
            dcount[i] = 0;  last_gap[i] = 0;  last_len[i] = 0;  last_rises[i] = 0;  last_img[i] = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset
        repeat (20) @(negedge clk);
        check("idle pins inst0", {sd_w[0], sclk_w[0], scs_w[0], busy_w[0]}, 4'b0010);
        check("idle pins inst1", {sd_w[1], sclk_w[1], scs_w[1], busy_w[1]}, 4'b0010);

        // table[k]=k, DIV=1
        for (int k = 0; k < 16; k++) do_write(0, 4'(k), 4'(k));
        pulse_start(0);
        wait_idle(0, 700);
        check("div1 image low", last_img[0][63:0], 64'hFEDCBA9876543210);
        check("div1 image pad", last_img[0][255:64], 192'h0);
        check("div1 rises", last_rises[0], 256);
        check("div1 busy len", last_len[0], 513);

        // DIV=3, table[5]=0xA
        do_write(1, 4'd5, 4'hA);
        pulse_start(1);
        wait_idle(1, 1700);
        check("div3 entry5", last_img[1][23:20], 4'hA);
        check("div3 image", last_img[1], 256'h00A00000);
        check("div3 busy len", last_len[1], 1539);

        // Write while busy is dropped
        pulse_start(0);
        repeat (10) @(negedge clk);
        wr_en_v[0] = 1'b1;  wr_addr_v[0] = 4'd0;  wr_data_v[0] = 4'hF;
        @(negedge clk);
        wr_en_v[0] = 1'b0;
        check("wr_drop pulse", drop_w[0], 1);
        @(negedge clk);
        check("wr_drop single", drop_w[0], 0);
        wait_idle(0, 700);
        check("frozen entry0", last_img[0][3:0], 4'h0);
        pulse_start(0);
        wait_idle(0, 700);
        check("old entry0 kept", last_img[0][63:0], 64'hFEDCBA9876543210);

        // Reset mid-load at bit 100
        pulse_start(0);
        n = 0;
        while (rises[0] < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached bit 100", rises[0] >= 100, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset pins", {sclk_w[0], scs_w[0], busy_w[0], done_w[0]}, 4'b0100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_start(0);
        wait_idle(0, 700);
        check("post-reset image", last_img[0], 256'h0);
        check("post-reset rises", last_rises[0], 256);

        // start held across done: two back-to-back loads
        do_write(0, 4'd15, 4'h9);
        start_v[0] = 1'b1;
        nd = 0;  n = 0;
        while (nd < 2 && n < 3000) begin
            @(negedge clk);
            n++;
            if (done_w[0]) nd++;
        end
        start_v[0] = 1'b0;
        check("two dones", nd, 2);
        repeat (5) @(negedge clk);
        check("b2b idle", busy_w[0], 0);
        check("b2b scs_n gap", last_gap[0], 1);
        check("b2b image", last_img[0][63:60], 4'h9);

        // start during busy ignored
        d0 = dcount[1];
        pulse_start(1);
        repeat (50) @(negedge clk);
        pulse_start(1);
        wait_idle(1, 1700);
        repeat (10) @(negedge clk);
        check("single done", dcount[1] - d0, 1);
        check("stays idle", busy_w[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
